tx_serial_fila_controle: RTL and testbench

// Sequencer in front of tx_serial_N2 (7 data bits, no parity, 2 stop bits).

---
 rtl/tx_serial_fila_controle_pkg.sv | 17 +
 rtl/tx_serial_fila_controle_if.sv | 32 +++
 rtl/tx_serial_fila_controle_fila.sv | 54 +++++
 rtl/tx_serial_fila_controle.sv | 107 ++++++++++
 tb/tb_tx_serial_fila_controle.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_serial_fila_controle_pkg.sv
// Shared state codes and default sizes for the serial transmit queue controller.
package tx_serial_fila_controle_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'b000,
    CARREGA = 3'b001,
    PARTIDA = 3'b010,
    ESPERA  = 3'b011,
    FINAL   = 3'b100,
    ERRO    = 3'b101
  } estado_t;

  localparam int LARG_ESTADO         = 3;
  localparam int LARG_DADO_PADRAO    = 7;
  localparam int PROFUNDIDADE_PADRAO = 8;

endpackage

// File: rtl/tx_serial_fila_controle_if.sv
// Producer-side and transmitter-side signals of the queue controller, plus debug taps.
interface tx_serial_fila_controle_if
  import tx_serial_fila_controle_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARG_DADO    = LARG_DADO_PADRAO
);
  logic                          escreve;
  logic [LARG_DADO-1:0]          dado_escrita;
  logic                          cheia;
  logic                          vazia;
  logic                          transbordo;
  logic                          erro;
  logic                          ocupado;
  logic                          tx_partida;
  logic [LARG_DADO-1:0]          tx_dados;
  logic                          tx_pronto;
  logic [LARG_ESTADO-1:0]        db_estado;
  logic [$clog2(PROFUNDIDADE):0] db_contagem;

  modport master (
    output escreve, dado_escrita, tx_pronto,
    input  cheia, vazia, transbordo, erro, ocupado, tx_partida, tx_dados,
           db_estado, db_contagem
  );

  modport slave (
    input  escreve, dado_escrita, tx_pronto,
    output cheia, vazia, transbordo, erro, ocupado, tx_partida, tx_dados,
           db_estado, db_contagem
  );
endinterface

// File: rtl/tx_serial_fila_controle_fila.sv
// Synchronous FIFO; combinational head read, write/pop take effect on the clock edge.
// A write while full is accepted only when a pop happens in the same cycle.
module fila_sincrona
  import tx_serial_fila_controle_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARG_DADO    = LARG_DADO_PADRAO
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          escreve,
  input  logic                          le,
  input  logic [LARG_DADO-1:0]          dado_escrita,
  output logic [LARG_DADO-1:0]          dado_leitura,
  output logic                          cheia,
  output logic                          vazia,
  output logic [$clog2(PROFUNDIDADE):0] contagem
);
  localparam int LARG_PTR  = $clog2(PROFUNDIDADE);
  localparam int LARG_CONT = LARG_PTR + 1;

  logic [LARG_DADO-1:0] mem [PROFUNDIDADE];
  logic [LARG_PTR-1:0]  ptr_esc;
  logic [LARG_PTR-1:0]  ptr_le;
  logic                 pop;
  logic                 aceita;

  assign pop          = le && !vazia;
  assign aceita       = escreve && (!cheia || pop);
  assign cheia        = (contagem == LARG_CONT'(PROFUNDIDADE));
  assign vazia        = (contagem == '0);
  assign dado_leitura = mem[ptr_le];

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (aceita) mem[ptr_esc] <= dado_escrita;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_esc  <= '0;
      ptr_le   <= '0;
      contagem <= '0;
    end else begin
      if (aceita) ptr_esc <= ptr_esc + LARG_PTR'(1);
      if (pop)    ptr_le  <= ptr_le + LARG_PTR'(1);
      case ({aceita, pop})
        2'b10:   contagem <= contagem + LARG_CONT'(1);
        2'b01:   contagem <= contagem - LARG_CONT'(1);
        default: contagem <= contagem;
      endcase
    end
  end
endmodule

// File: rtl/tx_serial_fila_controle.sv
// Queues characters and hands them one at a time to tx_serial_N2 via partida/pronto.
// First write to partida is 3 cycles; a missing pronto edge is abandoned after TIMEOUT cycles.
module tx_serial_fila_controle
  import tx_serial_fila_controle_pkg::*;
#(
  parameter int PROFUNDIDADE  = PROFUNDIDADE_PADRAO,
  parameter int LARG_DADO     = LARG_DADO_PADRAO,
  parameter int PULSO_PARTIDA = 1,
  parameter int TIMEOUT       = 100000
) (
  input logic                      clock,
  input logic                      reset,
  tx_serial_fila_controle_if.slave bus
);
  localparam int LARG_WD    = $clog2(TIMEOUT + 1);
  localparam int LARG_PULSO = $clog2(PULSO_PARTIDA + 1);

  estado_t                       estado;
  estado_t                       proximo;
  logic [LARG_WD-1:0]            cont_wd;
  logic [LARG_PULSO-1:0]         cont_pulso;
  logic                          pronto_ant;
  logic                          borda_pronto;
  logic                          estoura_wd;
  logic                          fim_pulso;
  logic                          le;
  logic                          aceita;
  logic                          partida_q;
  logic [LARG_DADO-1:0]          dados_q;
  logic                          transbordo_q;
  logic                          erro_q;
  logic [LARG_DADO-1:0]          cabeca;
  logic                          cheia;
  logic                          vazia;
  logic [$clog2(PROFUNDIDADE):0] contagem;

  fila_sincrona #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARG_DADO    (LARG_DADO)
  ) u_fila (
    .clock        (clock),
    .reset        (reset),
    .escreve      (bus.escreve),
    .le           (le),
    .dado_escrita (bus.dado_escrita),
    .dado_leitura (cabeca),
    .cheia        (cheia),
    .vazia        (vazia),
    .contagem     (contagem)
  );

  assign le           = (estado == CARREGA);
  assign aceita       = bus.escreve && (!cheia || le);
  assign borda_pronto = bus.tx_pronto && !pronto_ant;
  assign estoura_wd   = (cont_wd == LARG_WD'(TIMEOUT - 1));
  assign fim_pulso    = (cont_pulso == LARG_PULSO'(PULSO_PARTIDA - 1));

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL: if (!vazia) proximo = CARREGA;
      CARREGA: proximo = PARTIDA;
      PARTIDA: if (fim_pulso) proximo = ESPERA;
      ESPERA: begin
        if (borda_pronto)    proximo = FINAL;
        else if (estoura_wd) proximo = ERRO;
      end
      FINAL:   proximo = INICIAL;
      ERRO:    proximo = INICIAL;
      default: proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      partida_q    <= 1'b0;
      dados_q      <= '0;
      pronto_ant   <= 1'b0;
      cont_wd      <= '0;
      cont_pulso   <= '0;
      transbordo_q <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado     <= proximo;
      // Decoded from the next state so partida comes straight off a flop.
      partida_q  <= (proximo == PARTIDA);
      pronto_ant <= bus.tx_pronto;
      if (le) dados_q <= cabeca;
      cont_pulso <= (estado == PARTIDA) ? cont_pulso + LARG_PULSO'(1) : '0;
      cont_wd    <= (estado == ESPERA)  ? cont_wd + LARG_WD'(1)       : '0;
      if (bus.escreve && !aceita) transbordo_q <= 1'b1;
      if (estado == ESPERA && !borda_pronto && estoura_wd) erro_q <= 1'b1;
      else if (aceita)                                     erro_q <= 1'b0;
    end
  end

  assign bus.cheia       = cheia;
  assign bus.vazia       = vazia;
  assign bus.transbordo  = transbordo_q;
  assign bus.erro        = erro_q;
  assign bus.ocupado     = (estado != INICIAL);
  assign bus.tx_partida  = partida_q;
  assign bus.tx_dados    = dados_q;
  assign bus.db_estado   = estado;
  assign bus.db_contagem = contagem;
endmodule

// File: tb/tb_tx_serial_fila_controle.sv
// Bench: behavioural transmitter stub plus queue-level reference model for the queue controller.
module tb_tx_serial_fila_controle;
  localparam int PROF = 8;
  localparam int LD   = 7;
  localparam int TOUT = 50;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #10 clock = ~clock;

  tx_serial_fila_controle_if #(.PROFUNDIDADE(PROF), .LARG_DADO(LD)) bus ();

  tx_serial_fila_controle #(
    .PROFUNDIDADE  (PROF),
    .LARG_DADO     (LD),
    .PULSO_PARTIDA (1),
    .TIMEOUT       (TOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs != esp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Transmitter stub: records every frame start, answers with a one-cycle pronto pulse.
  logic [LD-1:0] got_q[$];
  int            partida_cyc_q[$];
  int            gap_q[$];
  bit            stall  = 1'b0;
  bit            manual = 1'b0;
  bit            busy   = 1'b0;
  bit            pronto_valid = 1'b0;
  int            last_pronto_cyc = 0;
  int            espera = 0;
  int            larg_partida = 0;
  logic [LD-1:0] atual = '0;

  initial begin
    bus.tx_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy = 1'b0; pronto_valid = 1'b0; larg_partida = 0;
        if (!manual) bus.tx_pronto = 1'b0;
      end else begin
        if (!manual && bus.tx_pronto) bus.tx_pronto = 1'b0;
        if (bus.tx_partida) begin
          if (larg_partida == 0) begin
            got_q.push_back(bus.tx_dados);
            partida_cyc_q.push_back(cyc);
            if (pronto_valid) gap_q.push_back(cyc - last_pronto_cyc);
            pronto_valid = 1'b0;
            atual  = bus.tx_dados;
            busy   = 1'b1;
            espera = $urandom_range(1, 15);
          end
          larg_partida++;
        end else begin
          if (larg_partida != 0) verifica("partida_width", larg_partida, 1);
          larg_partida = 0;
          if (busy && !stall && !manual) begin
            if (espera == 0) begin
              verifica("tx_dados_stable", int'(bus.tx_dados), int'(atual));
              bus.tx_pronto   = 1'b1;
              busy            = 1'b0;
              last_pronto_cyc = cyc;
              pronto_valid    = 1'b1;
            end else espera--;
          end
        end
      end
    end
  end

  logic [LD-1:0] lote[$];
  logic [LD-1:0] exp_q[$];

  task automatic escreve_lote();
    foreach (lote[i]) begin
      bus.escreve = 1'b1;
      bus.dado_escrita = lote[i];
      @(negedge clock);
    end
    bus.escreve = 1'b0;
  endtask

  task automatic pulsa_reset();
    bus.escreve = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    got_q.delete(); partida_cyc_q.delete(); gap_q.delete();
    @(negedge clock);
  endtask

  task automatic espera_estado(input string tag, input int e, input int lim);
    int ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (int'(bus.db_estado) == e) ok = 1;
      else @(negedge clock);
    end
    verifica(tag, ok, 1);
  endtask

  task automatic espera_ocioso(input string tag, input int lim);
    int ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (!bus.ocupado && bus.vazia && !busy) ok = 1;
      else @(negedge clock);
    end
    verifica(tag, ok, 1);
  endtask

  task automatic compara_frames(input string tag);
    verifica({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) verifica({tag, "_data"}, int'(got_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int c0, n, acc;
    logic [LD-1:0] d;
    bus.escreve = 1'b0;
    bus.dado_escrita = '0;

    // Reset state
    repeat (20) @(negedge clock);
    verifica("rst_vazia",      int'(bus.vazia), 1);
    verifica("rst_cheia",      int'(bus.cheia), 0);
    verifica("rst_partida",    int'(bus.tx_partida), 0);
    verifica("rst_ocupado",    int'(bus.ocupado), 0);
    verifica("rst_estado",     int'(bus.db_estado), 0);
    verifica("rst_contagem",   int'(bus.db_contagem), 0);
    verifica("rst_transbordo", int'(bus.transbordo), 0);
    verifica("rst_erro",       int'(bus.erro), 0);
    verifica("rst_tx_dados",   int'(bus.tx_dados), 0);
    reset = 1'b1;
    @(negedge clock);

    // Single character: latency and return to idle
    c0 = cyc;
    lote = '{7'h35};
    escreve_lote();
    for (int i = 0; i < 20 && got_q.size() == 0; i++) @(negedge clock);
    verifica("single_frame_seen", got_q.size(), 1);
    if (got_q.size() > 0) begin
      verifica("single_latency", partida_cyc_q[0] - c0, 3);
      verifica("single_data", int'(got_q[0]), 'h35);
    end
    espera_ocioso("single_idle", 100);
    verifica("single_vazia", int'(bus.vazia), 1);
    verifica("single_estado", int'(bus.db_estado), 0);

    // Back-to-back characters: order and 4-cycle gap after pronto
    pulsa_reset();
    lote = '{7'h35, 7'h55, 7'h7E, 7'h7F};
    exp_q = lote;
    escreve_lote();
    espera_ocioso("burst_idle", 400);
    compara_frames("burst");
    verifica("burst_gaps", gap_q.size(), 3);
    foreach (gap_q[i]) verifica("burst_gap", gap_q[i], 4);

    // Randomized fill against a stalled transmitter
    for (int it = 0; it < 8; it++) begin
      n = (it == 0) ? 9 : $urandom_range(1, 11);
      acc = (n > PROF) ? PROF : n;
      pulsa_reset();
      stall = 1'b1;
      exp_q.delete();
      d = LD'($urandom);
      lote = '{d};
      exp_q.push_back(d);
      escreve_lote();
      espera_estado("fill_espera", 3, 20);
      lote.delete();
      for (int k = 0; k < n; k++) begin
        d = LD'($urandom);
        lote.push_back(d);
        if (k < PROF) exp_q.push_back(d);
      end
      escreve_lote();
      verifica("fill_contagem",   int'(bus.db_contagem), acc);
      verifica("fill_cheia",      int'(bus.cheia), int'(n >= PROF));
      verifica("fill_transbordo", int'(bus.transbordo), int'(n > PROF));
      verifica("fill_vazia",      int'(bus.vazia), 0);
      stall = 1'b0;
      espera_ocioso("fill_idle", 1000);
      compara_frames("fill");
      verifica("fill_erro", int'(bus.erro), 0);
    end

    // Write while full is accepted only in the pop cycle
    pulsa_reset();
    stall = 1'b1;
    exp_q.delete();
    lote = '{7'h11};
    exp_q.push_back(7'h11);
    escreve_lote();
    espera_estado("full_espera", 3, 20);
    lote.delete();
    for (int k = 0; k < PROF; k++) begin
      lote.push_back(LD'(7'h20 + k));
      exp_q.push_back(LD'(7'h20 + k));
    end
    escreve_lote();
    verifica("full_cheia", int'(bus.cheia), 1);
    manual = 1'b1;
    bus.tx_pronto = 1'b1;
    @(negedge clock);
    bus.tx_pronto = 1'b0;
    repeat (2) @(negedge clock);
    verifica("full_carrega", int'(bus.db_estado), 1);
    bus.escreve = 1'b1;
    bus.dado_escrita = 7'h6A;
    exp_q.push_back(7'h6A);
    @(negedge clock);
    verifica("full_pop_write_transbordo", int'(bus.transbordo), 0);
    verifica("full_pop_write_contagem", int'(bus.db_contagem), PROF);
    bus.dado_escrita = 7'h15;
    @(negedge clock);
    bus.escreve = 1'b0;
    verifica("full_drop_transbordo", int'(bus.transbordo), 1);
    manual = 1'b0;
    stall  = 1'b0;
    espera_ocioso("full_idle", 1000);
    compara_frames("full");

    // A pronto level already high is not completion
    pulsa_reset();
    manual = 1'b1;
    bus.tx_pronto = 1'b1;
    lote = '{7'h41};
    escreve_lote();
    espera_estado("level_espera", 3, 20);
    repeat (10) @(negedge clock);
    verifica("level_hold", int'(bus.db_estado), 3);
    bus.tx_pronto = 1'b0;
    @(negedge clock);
    bus.tx_pronto = 1'b1;
    @(negedge clock);
    bus.tx_pronto = 1'b0;
    manual = 1'b0;
    busy = 1'b0;
    espera_ocioso("level_idle", 20);
    verifica("level_erro", int'(bus.erro), 0);

    // Watchdog: abort after TIMEOUT cycles, discard, continue with next entry
    pulsa_reset();
    stall = 1'b1;
    lote = '{7'h0A, 7'h0B};
    exp_q = '{7'h0A, 7'h0B, 7'h0C};
    escreve_lote();
    espera_estado("wd_espera", 3, 20);
    repeat (TOUT - 1) @(negedge clock);
    verifica("wd_erro_before", int'(bus.erro), 0);
    verifica("wd_estado_before", int'(bus.db_estado), 3);
    @(negedge clock);
    verifica("wd_erro_at", int'(bus.erro), 1);
    verifica("wd_estado_at", int'(bus.db_estado), 5);
    for (int i = 0; i < 10 && got_q.size() < 2; i++) @(negedge clock);
    verifica("wd_next_loaded", got_q.size(), 2);
    verifica("wd_erro_sticky", int'(bus.erro), 1);
    stall = 1'b0;
    lote = '{7'h0C};
    escreve_lote();
    verifica("wd_erro_cleared", int'(bus.erro), 0);
    espera_ocioso("wd_idle", 300);
    compara_frames("wd");

    // Reset while waiting with entries queued
    pulsa_reset();
    stall = 1'b1;
    lote = '{7'h01, 7'h02, 7'h03, 7'h04};
    escreve_lote();
    espera_estado("rstq_espera", 3, 20);
    verifica("rstq_contagem_before", int'(bus.db_contagem), 3);
    reset = 1'b0;
    #1;
    verifica("rstq_partida", int'(bus.tx_partida), 0);
    verifica("rstq_contagem", int'(bus.db_contagem), 0);
    verifica("rstq_estado", int'(bus.db_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stall = 1'b0;
    repeat (30) @(negedge clock);
    verifica("rstq_no_tx", got_q.size(), 1);
    verifica("rstq_ocupado", int'(bus.ocupado), 0);

    // Reset during the partida pulse drops it at once
    lote = '{7'h5A};
    escreve_lote();
    for (int i = 0; i < 10 && !bus.tx_partida; i++) @(negedge clock);
    verifica("rstp_partida_seen", int'(bus.tx_partida), 1);
    reset = 1'b0;
    #1;
    verifica("rstp_partida", int'(bus.tx_partida), 0);
    verifica("rstp_tx_dados", int'(bus.tx_dados), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
